// File: rtl/eth_rx_hdr_ctrl.sv
// eth_rx_hdr_ctrl
//   Sequencer in front of the Ethernet RX frame demux. Captures DST/SRC/TYPE
//   into a control word, pulses ctrl_vld once per frame, and delays the byte
//   stream by the header length so the demux select settles before byte 0
//   leaves. Drains the delay line at end of frame and truncates oversize frames.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   rx_byte/_vld      received byte and its valid
//   rx_sof            with rx_byte_vld: first byte of a frame
//   rx_eof            one-cycle pulse, frame ended (no byte that cycle)
//   rx_err            PHY error in current frame
//   ctrl/ctrl_vld     {DST, SRC, TYPE, BAD} and its one-cycle strobe
//   data_out          {byte_vld, byte} delayed stream; data_last marks last byte
//   busy              frame in progress (any state but IDLE)
//   drop_cnt          saturating count of SOFs rejected while busy
module eth_rx_hdr_ctrl #(
  parameter int P_HDR_BYTES = 14,
  parameter int P_MAX_BYTES = 1518
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_byte_vld,
  input  logic                       rx_sof,
  input  logic                       rx_eof,
  input  logic                       rx_err,
  output logic [8*P_HDR_BYTES:0]     ctrl,
  output logic                       ctrl_vld,
  output logic [8:0]                 data_out,
  output logic                       data_last,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);
  localparam int N  = P_HDR_BYTES;
  localparam int CW = 8*N + 1;
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_FLUSH, S_DISCARD} state_e;

  state_e               state_q, state_d;
  logic [N-1:0][7:0]    dl_q, dl_d;     // delay line, [0] newest
  logic [N-1:0]         dv_q, dv_d;     // per-entry valid, shifts with dl
  logic [N-1:0][7:0]    hdr_q, hdr_d;   // [i] = header byte i
  logic [10:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        ctrl_q, ctrl_d;
  logic                 ctrl_vld_q, ctrl_vld_d;
  logic [8:0]           dout_q, dout_d;
  logic                 last_q, last_d;
  logic [15:0]          drop_q, drop_d;

  logic shift, vin, last_out, acc;

  assign acc = rx_byte_vld & ~rx_sof;

  // Header byte 0 lands in the MSBs: {DST, SRC, TYPE, BAD}.
  function automatic logic [CW-1:0] pack(input logic [N-1:0][7:0] h, input logic bad);
    logic [CW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[CW-1-8*i -: 8] = h[i];
    p[0] = bad;
    return p;
  endfunction

  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    dv_d       = dv_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ctrl_d     = ctrl_q;
    ctrl_vld_d = 1'b0;
    dout_d     = '0;
    last_d     = 1'b0;
    drop_d     = drop_q;
    shift      = 1'b0;
    vin        = 1'b0;

    if (rx_byte_vld && rx_sof && state_q != S_IDLE && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (rx_byte_vld && rx_sof) begin
          hdr_d    = '0;
          hdr_d[0] = rx_byte;
          cnt_d    = 11'd1;
          err_d    = rx_err;
          shift    = 1'b1;
          vin      = 1'b1;
          state_d  = S_HDR;
        end
      end
      S_HDR: begin
        err_d = err_q | rx_err;
        if (rx_eof) begin
          // runt: unfilled header bytes are already zero
          ctrl_d     = pack(hdr_q, 1'b1);
          ctrl_vld_d = 1'b1;
          state_d    = S_FLUSH;
        end else if (acc) begin
          hdr_d[cnt_q[IW-1:0]] = rx_byte;
          shift = 1'b1;
          vin   = 1'b1;
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == 11'(N-1)) begin
            ctrl_d     = pack(hdr_d, err_q | rx_err);
            ctrl_vld_d = 1'b1;
            state_d    = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_eof) state_d = S_FLUSH;
        else if (acc) begin
          shift = 1'b1;
          // Bytes past the limit still push the line forward but enter
          // marked invalid, so exactly P_MAX_BYTES leave.
          vin   = (cnt_q < 11'(P_MAX_BYTES));
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_FLUSH:   shift = 1'b1;
      S_DISCARD: if (rx_eof) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Outgoing entry is last when nothing valid remains behind it.
    last_out = shift & dv_q[N-1] & ~(|dv_q[N-2:0]) & ~vin;

    if (shift) begin
      dl_d = {dl_q[N-2:0], rx_byte};
      dv_d = {dv_q[N-2:0], vin};
      if (dv_q[N-1]) dout_d = {1'b1, dl_q[N-1]};
      last_d = last_out;
    end

    if (last_out) state_d = (state_q == S_PAYLOAD) ? S_DISCARD : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dl_q       <= '0;
      dv_q       <= '0;
      hdr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ctrl_q     <= '0;
      ctrl_vld_q <= 1'b0;
      dout_q     <= '0;
      last_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      dv_q       <= dv_d;
      hdr_q      <= hdr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ctrl_q     <= ctrl_d;
      ctrl_vld_q <= ctrl_vld_d;
      dout_q     <= dout_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign ctrl_vld  = ctrl_vld_q;
  assign data_out  = dout_q;
  assign data_last = last_q;
  assign busy      = (state_q != S_IDLE);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_eth_rx_hdr_ctrl.sv
module tb_eth_rx_hdr_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_byte;
  logic         rx_byte_vld, rx_sof, rx_eof, rx_err;
  logic [112:0] ctrl;
  logic         ctrl_vld;
  logic [8:0]   data_out;
  logic         data_last, busy;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  eth_rx_hdr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .ctrl(ctrl),
    .ctrl_vld(ctrl_vld), .data_out(data_out), .data_last(data_last),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0]   exp_d[$];
  logic [112:0] exp_c[$];
  logic [7:0]   fb [0:1599];
  logic         mon_en = 1'b0;
  logic         ctrl_seen = 1'b0;

  localparam logic [112:0] C_BCAST = {48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 1'b0};
  localparam logic [112:0] C_UNI_B = {48'h00183E02523A, 48'h020000000001, 16'h0800, 1'b1};
  localparam logic [112:0] C_UNI_G = {48'h00183E02523A, 48'h020000000001, 16'h0800, 1'b0};
  localparam logic [112:0] C_RUNT  = {48'h010203040506, 48'h0, 16'h0, 1'b1};
  localparam logic [112:0] C_BIG   = {48'hAABBCCDDEE01, 48'h102030405060, 16'h88B5, 1'b0};
  localparam logic [112:0] C_DROP  = {48'h303132333435, 48'h363738393A3B, 16'h3C3D, 1'b0};

  // Monitor: pops the scoreboard whenever the DUT presents output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_out[8]) begin
        checks++;
        if (exp_d.size() == 0) begin
          failures++;
          $display("FAIL data_unexpected: got last=%0b byte=%h, expected no byte", data_last, data_out[7:0]);
        end else begin
          logic [8:0] e;
          e = exp_d.pop_front();
          if ({data_last, data_out[7:0]} !== e) begin
            failures++;
            $display("FAIL data: got last=%0b byte=%h, expected last=%0b byte=%h",
                     data_last, data_out[7:0], e[8], e[7:0]);
          end
        end
        if (!ctrl_seen) begin
          failures++;
          $display("FAIL order: byte %h out before ctrl_vld, expected ctrl_vld first", data_out[7:0]);
        end
        if (data_last) ctrl_seen = 1'b0;
      end else if (data_out !== 9'h0 || data_last !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL idle_out: got data_out=%h last=%b, expected 0", data_out, data_last);
      end
      if (ctrl_vld) begin
        checks++;
        if (exp_c.size() == 0) begin
          failures++;
          $display("FAIL ctrl_unexpected: got %h, expected no ctrl_vld", ctrl);
        end else begin
          logic [112:0] ec;
          ec = exp_c.pop_front();
          if (ctrl !== ec) begin
            failures++;
            $display("FAIL ctrl: got %h, expected %h", ctrl, ec);
          end
        end
        ctrl_seen = 1'b1;
      end
      if (!rst_n) ctrl_seen = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic set_hdr(input logic [111:0] h);
    for (int i = 0; i < 14; i++) fb[i] = h[111-8*i -: 8];
  endtask

  task automatic fill_pl(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fb[14+i] = base + 8'(i);
  endtask

  // Drives one frame; pushes its expected ctrl word and forwarded bytes first.
  task automatic send_frame(input int len, input int err_at, input int rst_at,
                            input bit gap, input bit sof_after, input logic [112:0] expc);
    int n;
    exp_c.push_back(expc);
    if (rst_at >= 0) n = rst_at - 14;
    else n = (len < 1518) ? len : 1518;
    for (int i = 0; i < n; i++)
      exp_d.push_back({(rst_at < 0) && (i == n-1), fb[i]});
    for (int i = 0; i < len; i++) begin
      rx_byte = fb[i]; rx_byte_vld = 1'b1; rx_sof = (i == 0); rx_err = (i == err_at);
      if (i == rst_at) rst_n = 1'b0;
      cyc();
      rx_byte_vld = 1'b0; rx_sof = 1'b0; rx_err = 1'b0;
      if (i == rst_at) begin
        rst_n = 1'b1;
        return;
      end
      if (gap && (i % 3 == 2)) cyc();
    end
    rx_eof = 1'b1;
    cyc();
    rx_eof = 1'b0;
    if (sof_after) begin
      rx_byte = 8'h55; rx_byte_vld = 1'b1; rx_sof = 1'b1;
      cyc();
      rx_byte_vld = 1'b0; rx_sof = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s_idle: busy still 1 after %0d cycles, expected 0", nm, n);
    end
    repeat (2) cyc();
  endtask

  initial begin
    rst_n = 1'b0; rx_byte = '0; rx_byte_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    repeat (3) cyc();
    chk("rst_ctrl", 128'(ctrl), 128'h0);
    chk("rst_ctrl_vld", 128'(ctrl_vld), 128'h0);
    chk("rst_data_out", 128'(data_out), 128'h0);
    chk("rst_data_last", 128'(data_last), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_drop_cnt", 128'(drop_cnt), 128'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc();

    // broadcast ARP, 28B payload
    set_hdr(112'hFFFFFFFFFFFF_001122334455_0806);
    fill_pl(28, 8'hA0);
    send_frame(42, -1, -1, 1'b0, 1'b0, C_BCAST);
    wait_idle("bcast");
    chk("ctrl_hold", 128'(ctrl), 128'(C_BCAST));

    // unicast with rx_err on byte 5, gapped input
    set_hdr(112'h00183E02523A_020000000001_0800);
    fill_pl(10, 8'h50);
    send_frame(24, 5, -1, 1'b1, 1'b0, C_UNI_B);
    wait_idle("uni_err");

    // runt: EOF after 6 bytes; filler beyond byte 5 must not leak into ctrl
    set_hdr(112'h010203040506_9999999999999999);
    send_frame(6, -1, -1, 1'b0, 1'b0, C_RUNT);
    wait_idle("runt");

    // oversize 1600B
    set_hdr(112'hAABBCCDDEE01_102030405060_88B5);
    for (int i = 14; i < 1600; i++) fb[i] = 8'(i);
    send_frame(1600, -1, -1, 1'b0, 1'b0, C_BIG);
    wait_idle("oversize");

    // SOF arriving during FLUSH
    chk("drop_before", 128'(drop_cnt), 128'h0);
    set_hdr(112'h303132333435_363738393A3B_3C3D);
    fill_pl(6, 8'h70);
    send_frame(20, -1, -1, 1'b0, 1'b1, C_DROP);
    wait_idle("drop");
    chk("drop_after", 128'(drop_cnt), 128'h1);

    // reset for one cycle at byte 20
    set_hdr(112'hFFFFFFFFFFFF_001122334455_0806);
    fill_pl(26, 8'hC0);
    send_frame(40, -1, 20, 1'b0, 1'b0, C_BCAST);
    chk("mid_rst_data_out", 128'(data_out), 128'h0);
    chk("mid_rst_data_last", 128'(data_last), 128'h0);
    chk("mid_rst_ctrl", 128'(ctrl), 128'h0);
    chk("mid_rst_ctrl_vld", 128'(ctrl_vld), 128'h0);
    chk("mid_rst_busy", 128'(busy), 128'h0);
    chk("mid_rst_drop_cnt", 128'(drop_cnt), 128'h0);
    repeat (2) cyc();

    // following frame decodes normally
    set_hdr(112'h00183E02523A_020000000001_0800);
    fill_pl(10, 8'h20);
    send_frame(24, -1, -1, 1'b0, 1'b0, C_UNI_G);
    wait_idle("post_rst");

    repeat (5) cyc();
    chk("data_queue_empty", 128'(exp_d.size()), 128'h0);
    chk("ctrl_queue_empty", 128'(exp_c.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
